// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and the
// baud-tick divisor calculation used by both rx and tx blocks.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

    // Rounded clk/(baud*os), never below 1 so the tick generator stays legal.
    function automatic int baud_div(input int clk_hz, input int baud, input int os);
        int den;
        int q;
        den = baud * os;
        q   = (clk_hz + den / 2) / den;
        return (q < 1) ? 1 : q;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divide-by-DIV tick generator; tick is high for one clk
// every DIV clks.
module uart_baud_tick #(
    parameter int DIV = 78
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampled 3-sample
// majority vote, configurable data/parity/stop framing with error reporting.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxEn,
    input  logic                 rx,
    output logic                 rxBusy,
    output logic                 rxDone,
    output logic                 rxErr,
    output logic                 rxParityErr,
    output logic                 rxBreak,
    output logic [DATA_BITS-1:0] out
);

    localparam int DIV = baud_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int S_W = $clog2(OVERSAMPLE);
    localparam logic [S_W-1:0] S_LO   = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2);
    localparam logic [S_W-1:0] S_VOTE = S_W'(OVERSAMPLE / 2 + 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [3:0] DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic PARITY_ON  = (PARITY != PARITY_NONE);
    localparam logic PARITY_INV = (PARITY == PARITY_ODD);

    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("OVERSAMPLE must be even and at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end

    logic tick;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    rx_state_e            state_q, state_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_sync_q, rx_sync_d;
    logic [S_W-1:0]       s_q, s_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 seen_one_q, seen_one_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 perr_q, perr_d;
    logic                 brk_q, brk_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 vote;
    logic                 exp_par;

    assign vote    = majority3(samp_q[0], samp_q[1], rx_sync_q);
    assign exp_par = (^shift_q) ^ PARITY_INV;

    always_comb begin
        rx_meta_d  = rx;
        rx_sync_d  = rx_meta_q;
        state_d    = state_q;
        s_d        = s_q;
        bit_cnt_d  = bit_cnt_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        seen_one_d = seen_one_q;
        out_d      = out_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        perr_d     = 1'b0;
        brk_d      = 1'b0;

        if (state_q != ST_IDLE && !rxEn) begin
            state_d = ST_IDLE;
        end else if (tick) begin
            if (state_q == ST_IDLE) begin
                if (rxEn && !rx_sync_q) begin
                    state_d    = ST_START;
                    s_d        = '0;
                    seen_one_d = 1'b0;
                end
            end else if (state_q == ST_WAIT_IDLE) begin
                // Stay busy through a held-low line so it never looks like a start bit.
                if (rx_sync_q) begin
                    state_d = ST_IDLE;
                end
            end else begin
                s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;
                if (s_q == S_LO) begin
                    samp_d[0] = rx_sync_q;
                end
                if (s_q == S_MID) begin
                    samp_d[1] = rx_sync_q;
                end
                if (s_q == S_VOTE) begin
                    if (vote) begin
                        seen_one_d = 1'b1;
                    end
                    case (state_q)
                        ST_START: begin
                            if (vote) begin
                                state_d = ST_IDLE;
                            end
                        end
                        ST_DATA:   shift_d   = {vote, shift_q[DATA_BITS-1:1]};
                        ST_PARITY: par_bit_d = vote;
                        ST_STOP: begin
                            if (!vote) begin
                                err_d   = 1'b1;
                                brk_d   = !seen_one_q;
                                state_d = ST_WAIT_IDLE;
                            end else if (bit_cnt_q == STOP_LAST) begin
                                done_d  = 1'b1;
                                perr_d  = PARITY_ON && (exp_par != par_bit_q);
                                out_d   = shift_q;
                                state_d = ST_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
                // Bit boundaries advance the framing; votes above stay mid-bit.
                if (s_q == S_LAST) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    case (state_q)
                        ST_START: begin
                            state_d   = ST_DATA;
                            bit_cnt_d = '0;
                        end
                        ST_DATA: begin
                            if (bit_cnt_q == DATA_LAST) begin
                                state_d   = PARITY_ON ? ST_PARITY : ST_STOP;
                                bit_cnt_d = '0;
                            end
                        end
                        ST_PARITY: begin
                            state_d   = ST_STOP;
                            bit_cnt_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            s_q        <= '0;
            bit_cnt_q  <= '0;
            seen_one_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            perr_q     <= 1'b0;
            brk_q      <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            s_q        <= s_d;
            bit_cnt_q  <= bit_cnt_d;
            seen_one_q <= seen_one_d;
            done_q     <= done_d;
            err_q      <= err_d;
            perr_q     <= perr_d;
            brk_q      <= brk_d;
            out_q      <= out_d;
        end
        samp_q    <= samp_d;
        shift_q   <= shift_d;
        par_bit_q <= par_bit_d;
    end

    assign rxBusy      = (state_q != ST_IDLE);
    assign rxDone      = done_q;
    assign rxErr       = err_q;
    assign rxParityErr = perr_q;
    assign rxBreak     = brk_q;
    assign out         = out_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: one default 8N1 instance plus three
// fast-clock instances covering 8N1, 7E1 and 9N2 framing.
module tb_uart_rx_param;

    localparam int FAST_CLK = 614400;   // DIV = 4, 64 clk per bit
    localparam int FB = 64;

    logic clk = 1'b0;
    logic rst;
    logic rst_c;
    logic [3:0] rx_line;
    logic [3:0] en;

    wire [3:0] busy_w, done_w, err_w, perr_w, brk_w;
    wire [7:0] out0, out1;
    wire [6:0] out2;
    wire [8:0] out3;
    logic [8:0] out_w [4];

    always #5 clk = ~clk;

    always_comb begin
        out_w[0] = {1'b0, out0};
        out_w[1] = {1'b0, out1};
        out_w[2] = {2'b00, out2};
        out_w[3] = out3;
    end

    uart_rx_param u_def (
        .clk(clk), .reset(rst), .rxEn(en[0]), .rx(rx_line[0]),
        .rxBusy(busy_w[0]), .rxDone(done_w[0]), .rxErr(err_w[0]),
        .rxParityErr(perr_w[0]), .rxBreak(brk_w[0]), .out(out0)
    );

    uart_rx_param #(.CLOCK_RATE(FAST_CLK)) u_a (
        .clk(clk), .reset(rst), .rxEn(en[1]), .rx(rx_line[1]),
        .rxBusy(busy_w[1]), .rxDone(done_w[1]), .rxErr(err_w[1]),
        .rxParityErr(perr_w[1]), .rxBreak(brk_w[1]), .out(out1)
    );

    uart_rx_param #(.CLOCK_RATE(FAST_CLK), .DATA_BITS(7), .PARITY(1)) u_b (
        .clk(clk), .reset(rst), .rxEn(en[2]), .rx(rx_line[2]),
        .rxBusy(busy_w[2]), .rxDone(done_w[2]), .rxErr(err_w[2]),
        .rxParityErr(perr_w[2]), .rxBreak(brk_w[2]), .out(out2)
    );

    uart_rx_param #(.CLOCK_RATE(FAST_CLK), .DATA_BITS(9), .STOP_BITS(2)) u_c (
        .clk(clk), .reset(rst | rst_c), .rxEn(en[3]), .rx(rx_line[3]),
        .rxBusy(busy_w[3]), .rxDone(done_w[3]), .rxErr(err_w[3]),
        .rxParityErr(perr_w[3]), .rxBreak(brk_w[3]), .out(out3)
    );

    typedef struct {
        string      name;
        int         inst;
        logic       done;
        logic       err;
        logic       perr;
        logic       brk;
        logic [8:0] data;
    } exp_t;

    exp_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic push_exp(input string name, input int inst, input logic done,
                            input logic err, input logic perr, input logic brk,
                            input logic [8:0] data);
        exp_t e;
        e.name = name; e.inst = inst; e.done = done; e.err = err;
        e.perr = perr; e.brk = brk; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s actual=%0d events outstanding required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic drive(input int idx, input logic v, input int clks);
        rx_line[idx] = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_data_bits(input int idx, input int bitclk, input logic [8:0] data,
                                  input int nbits);
        for (int b = 0; b < nbits; b++) drive(idx, data[b], bitclk);
    endtask

    task automatic send_frame(input int idx, input int bitclk, input logic [8:0] data,
                              input int nbits, input bit has_par, input logic pbit,
                              input int nstop);
        drive(idx, 1'b0, bitclk);
        send_data_bits(idx, bitclk, data, nbits);
        if (has_par) drive(idx, pbit, bitclk);
        for (int b = 0; b < nstop; b++) drive(idx, 1'b1, bitclk);
    endtask

    // Monitor: every output pulse is matched against the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (done_w[i] | err_w[i] | perr_w[i] | brk_w[i]) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event inst=%0d done/err/perr/brk=%b%b%b%b out=%0h required no event",
                             i, done_w[i], err_w[i], perr_w[i], brk_w[i], out_w[i]);
                end else begin
                    e = exp_q.pop_front();
                    if (e.inst != i || e.done != done_w[i] || e.err != err_w[i] ||
                        e.perr != perr_w[i] || e.brk != brk_w[i] || e.data != out_w[i]) begin
                        n_fail++;
                        $display("FAIL %s actual inst=%0d done/err/perr/brk=%b%b%b%b out=%0h required inst=%0d %b%b%b%b out=%0h",
                                 e.name, i, done_w[i], err_w[i], perr_w[i], brk_w[i], out_w[i],
                                 e.inst, e.done, e.err, e.perr, e.brk, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        rst = 1'b1; rst_c = 1'b0; rx_line = 4'hF; en = 4'hF;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", int'(busy_w), 0);
        check("reset_done", int'(done_w), 0);
        check("reset_err_flags", int'(err_w | perr_w | brk_w), 0);
        for (int i = 0; i < 4; i++) check("reset_out", int'(out_w[i]), 0);

        // Default parameters, bit period +3% and -3% of the nominal 1248 clk.
        push_exp("def_b5_slow", 0, 1, 0, 0, 0, 9'h0B5);
        send_frame(0, 1285, 9'h0B5, 8, 0, 1'b0, 1);
        wait_drain("def_b5_slow_drain", 2500);
        push_exp("def_3c_fast", 0, 1, 0, 0, 0, 9'h03C);
        send_frame(0, 1211, 9'h03C, 8, 0, 1'b0, 1);
        wait_drain("def_3c_fast_drain", 2500);
        check("def_idle_busy", int'(busy_w[0]), 0);

        // Fast 8N1: normal, framing error, recovery, back-to-back, break, glitch, abort.
        drive(1, 1'b1, FB);
        push_exp("a_5a", 1, 1, 0, 0, 0, 9'h05A);
        send_frame(1, FB, 9'h05A, 8, 0, 1'b0, 1);
        wait_drain("a_5a_drain", 4 * FB);

        push_exp("a_frame_err", 1, 0, 1, 0, 0, 9'h05A);
        drive(1, 1'b0, FB);
        send_data_bits(1, FB, 9'h0B5, 8);
        drive(1, 1'b0, 51);
        drive(1, 1'b1, 20);
        check("a_ferr_busy_low", int'(busy_w[1]), 0);
        wait_drain("a_frame_err_drain", 4 * FB);
        drive(1, 1'b1, FB);
        push_exp("a_3c_after_err", 1, 1, 0, 0, 0, 9'h03C);
        send_frame(1, FB, 9'h03C, 8, 0, 1'b0, 1);
        wait_drain("a_3c_drain", 4 * FB);

        push_exp("a_b2b_c3", 1, 1, 0, 0, 0, 9'h0C3);
        push_exp("a_b2b_0f", 1, 1, 0, 0, 0, 9'h00F);
        send_frame(1, FB, 9'h0C3, 8, 0, 1'b0, 1);
        send_frame(1, FB, 9'h00F, 8, 0, 1'b0, 1);
        wait_drain("a_b2b_drain", 4 * FB);

        push_exp("a_break", 1, 0, 1, 0, 1, 9'h00F);
        drive(1, 1'b0, 12 * FB);
        check("a_break_hold_busy", int'(busy_w[1]), 1);
        drive(1, 1'b1, 20);
        check("a_break_release_busy", int'(busy_w[1]), 0);
        wait_drain("a_break_drain", 4 * FB);

        drive(1, 1'b1, FB);
        seen = 1'b0;
        rx_line[1] = 1'b0;
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            if (busy_w[1]) seen = 1'b1;
        end
        rx_line[1] = 1'b1;
        for (int k = 0; k < 3 * FB; k++) begin
            @(negedge clk);
            if (busy_w[1]) seen = 1'b1;
        end
        check("a_glitch_busy_seen", int'(seen), 1);
        check("a_glitch_busy_clear", int'(busy_w[1]), 0);

        drive(1, 1'b0, FB);
        send_data_bits(1, FB, 9'h081, 3);
        check("a_abort_pre_busy", int'(busy_w[1]), 1);
        en[1] = 1'b0;
        @(negedge clk);
        check("a_abort_busy", int'(busy_w[1]), 0);
        drive(1, 1'b0, 4 * FB);
        drive(1, 1'b1, 2 * FB);
        en[1] = 1'b1;
        repeat (FB) @(negedge clk);
        check("a_abort_idle_busy", int'(busy_w[1]), 0);
        check("a_abort_out", int'(out_w[1]), 'h0F);

        // 7E1: 0x55 has four ones, so the even parity bit is 0.
        push_exp("b_par_bad", 2, 1, 0, 1, 0, 9'h055);
        send_frame(2, FB, 9'h055, 7, 1, 1'b1, 1);
        wait_drain("b_par_bad_drain", 4 * FB);
        push_exp("b_par_ok", 2, 1, 0, 0, 0, 9'h055);
        send_frame(2, FB, 9'h055, 7, 1, 1'b0, 1);
        wait_drain("b_par_ok_drain", 4 * FB);

        // 9N2: bad second stop bit, clean resend, then reset mid-frame.
        push_exp("c_stop2_err", 3, 0, 1, 0, 0, 9'h000);
        drive(3, 1'b0, FB);
        send_data_bits(3, FB, 9'h1A5, 9);
        drive(3, 1'b1, FB);
        drive(3, 1'b0, FB);
        drive(3, 1'b1, 2 * FB);
        wait_drain("c_stop2_err_drain", 4 * FB);
        push_exp("c_1a5", 3, 1, 0, 0, 0, 9'h1A5);
        send_frame(3, FB, 9'h1A5, 9, 0, 1'b0, 2);
        wait_drain("c_1a5_drain", 4 * FB);

        drive(3, 1'b1, FB);
        drive(3, 1'b0, FB);
        send_data_bits(3, FB, 9'h1A5, 4);
        check("c_pre_rst_busy", int'(busy_w[3]), 1);
        rst_c = 1'b1;
        @(negedge clk);
        rst_c = 1'b0;
        rx_line[3] = 1'b1;
        check("c_rst_busy", int'(busy_w[3]), 0);
        check("c_rst_out", int'(out_w[3]), 0);
        check("c_rst_pulses", int'({done_w[3], err_w[3], perr_w[3], brk_w[3]}), 0);
        repeat (4 * FB) @(negedge clk);
        check("c_rst_idle_busy", int'(busy_w[3]), 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
